bus_test_master: RTL and testbench
==================================

Name: bus_test_master

Overview:
Parametrised self-running bus master for bring-up of picorv32-bus peripherals such as the GPIO, UART TX and timer blocks. At a programmable period it issues one transaction on the shared mem_* bus and holds it until the mem_ready handshake completes or a timeout fires. Three modes are supported: counter write, message write, and write-then-readback with compare. Error, overrun and transaction counters are exported for LEDs and probes. It replaces the fixed, handshake-less gpio/uart test drivers and sits where the CPU would sit in the top level.

Parameters:
TICK_PERIOD, 5000000, clk cycles between transaction launches (>=2)
TARGET_ADDR, 32'hffff0040, bus address written and read
DATA_W, 8, payload width, 1..32
MSG_DEPTH, 16, message buffer entries, power of two
TIMEOUT, 255, max cycles mem_valid is held waiting for mem_ready

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
enable  in  1  permits new launches
mode  in  2  0=counter write, 1=message write, 2=write+readback, 3=reserved (no launch)
msg_len  in  log2(MSG_DEPTH)+1  active message entries, 0 is treated as 1
msg_we  in  1  message buffer write strobe
msg_waddr  in  log2(MSG_DEPTH)  message buffer write index
msg_wdata  in  DATA_W  message buffer write data
mem_valid  out  1  bus request
mem_instr  out  1  always 0
mem_addr  out  32  TARGET_ADDR while valid, else 0
mem_wstrb  out  4  write strobes, 0 for reads and when idle
mem_wdata  out  32  zero-extended payload while writing, else 0
mem_ready  in  1  bus acknowledge
mem_rdata  in  32  read data
busy  out  1  state != IDLE
txn_count  out  16  completed launches, wraps
err_count  out  8  timeouts plus mismatches, saturates at 255
timeout_flag  out  1  sticky
mismatch_flag  out  1  sticky
overrun_flag  out  1  sticky: tick arrived while busy

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, msg index 0, tick counter loaded with TICK_PERIOD-1. Message buffer contents are not reset.
- Tick: one-cycle pulse when the down-counter reaches 0, then it reloads. The counter runs regardless of enable.
- IDLE: on tick with enable=1 and mode!=3, latch mode and payload and go to WRITE. mem_valid rises the cycle after the tick (registered outputs).
- Payload: mode 0 uses the counter value; mode 1 uses msg[index]. After a write completes, the counter increments mod 2^DATA_W (mode 0) or the index increments and wraps to 0 at msg_len (mode 1). Mode 2 uses the counter payload.
- mem_wstrb on write = lower ceil(DATA_W/8) bits set.
- WRITE: addr, wdata and wstrb are held stable while mem_valid=1.
  - mem_ready=1 sampled: mem_valid drops next cycle. Go to READ if mode 2, else to IDLE with txn_count++.
  - Wait counter reaches TIMEOUT without ready: drop valid, set timeout_flag, err_count++, txn_count++, go to IDLE. The payload does not advance.
- READ (mode 2): mem_valid=1, wstrb=0, wdata=0, same address.
  - On ready: compare mem_rdata[DATA_W-1:0] with the written payload. On mismatch, set mismatch_flag and err_count++. Then txn_count++ and go to IDLE.
  - Timeout handling is identical to WRITE.
- The wait counter restarts at 0 on entry to each of WRITE and READ.
- A tick while busy sets overrun_flag and is dropped, never queued.
- enable falling mid-transaction has no effect; the transaction finishes.
- If ready and the TIMEOUT expiry land in the same cycle, ready wins.
- mode and msg_len changes take effect only at launch.
- A msg_we to the entry being sent takes effect at the next launch, because the payload is latched at launch.
- resetn low mid-transaction: mem_valid=0 on the next edge.

Decomposition:
- Package bus_test_pkg holds:
  - mode encodings (MODE_CNT, MODE_MSG, MODE_RDBK)
  - state enum (IDLE, WRITE, READ)
  - wstrb_for_width function
- Sub-module period_tick (parametrised TICK_PERIOD) holds the reloadable down-counter and its tick output.

Test Plan:
- TICK_PERIOD=10, mode 0, ready one cycle after valid: writes with wdata 0,1,2,3 spaced 10 cycles apart, wstrb=4'b0001, txn_count=4, err_count=0.
- Mode 1, msg "Hi!" with msg_len=3: wdata sequence 0x48,0x69,0x21,0x48 (index wraps).
- Mode 0, ready tied low, TIMEOUT=5: valid held 5 cycles then drops, timeout_flag=1, err_count=1, next payload still 0.
- Mode 2, rdata returns payload^1: write then read with wstrb=0, mismatch_flag=1, err_count increments per launch, txn_count also increments.
- Ready held off 12 cycles with TICK_PERIOD=10, TIMEOUT=255: overrun_flag=1, exactly one transaction completes.
- resetn asserted mid-WRITE: mem_valid=0 next cycle, all counters and flags 0, first post-reset launch sends payload 0.

Source files
------------

// File: rtl/bus_test_pkg.sv
// Shared encodings for the bus test master: launch modes, FSM states and
// the write-strobe helper used to size byte lanes from the payload width.
package bus_test_pkg;

    typedef enum logic [1:0] {
        MODE_CNT  = 2'd0,
        MODE_MSG  = 2'd1,
        MODE_RDBK = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    // One strobe bit per byte lane the payload touches, starting at lane 0.
    function automatic logic [3:0] wstrb_for_width(input int w);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            if (i * 8 < w) s[i] = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/period_tick.sv
// Free-running reloadable down-counter; tick_o pulses for one cycle every
// TICK_PERIOD cycles, first pulse TICK_PERIOD cycles after reset release.
module period_tick #(
    parameter int unsigned TICK_PERIOD = 5000000
) (
    input  logic clk,
    input  logic resetn,
    output logic tick_o
);

    localparam int unsigned CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_PERIOD - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn)          cnt_q <= RELOAD;
        else if (cnt_q == '0) cnt_q <= RELOAD;
        else                  cnt_q <= cnt_q - 1'b1;
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/bus_test_master.sv
// Self-running picorv32-bus master: launches one write (optionally followed
// by a readback compare) per tick and exports counters and sticky flags.
module bus_test_master
    import bus_test_pkg::*;
#(
    parameter int unsigned TICK_PERIOD = 5000000,
    parameter logic [31:0] TARGET_ADDR = 32'hffff0040,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MSG_DEPTH   = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         msg_we,
    input  logic [$clog2(MSG_DEPTH)-1:0] msg_waddr,
    input  logic [DATA_W-1:0]            msg_wdata,
    output logic                         mem_valid,
    output logic                         mem_instr,
    output logic [31:0]                  mem_addr,
    output logic [3:0]                   mem_wstrb,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_ready,
    input  logic [31:0]                  mem_rdata,
    output logic                         busy,
    output logic [15:0]                  txn_count,
    output logic [7:0]                   err_count,
    output logic                         timeout_flag,
    output logic                         mismatch_flag,
    output logic                         overrun_flag
);

    localparam int unsigned IW = $clog2(MSG_DEPTH);
    localparam int unsigned LW = IW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  WSTRB = wstrb_for_width(DATA_W);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [LW-1:0]     len_q, len_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [15:0]       txn_q, txn_d;
    logic [7:0]        err_q, err_d;
    logic              tflag_q, tflag_d, mflag_q, mflag_d, oflag_q, oflag_d;
    logic              tick, err_inc, timed_out;
    logic [31:0]       wdata_ext;
    logic              unused_rdata;

    logic [DATA_W-1:0] msg_mem [MSG_DEPTH];

    period_tick #(.TICK_PERIOD(TICK_PERIOD)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick_o (tick)
    );

    // Message contents survive reset so a loaded string need not be reloaded.
    always_ff @(posedge clk) begin
        if (msg_we) msg_mem[msg_waddr] <= msg_wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            mode_q    <= MODE_CNT;
            payload_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            len_q     <= LW'(1);
            wait_q    <= '0;
            txn_q     <= '0;
            err_q     <= '0;
            tflag_q   <= 1'b0;
            mflag_q   <= 1'b0;
            oflag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            payload_q <= payload_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            wait_q    <= wait_d;
            txn_q     <= txn_d;
            err_q     <= err_d;
            tflag_q   <= tflag_d;
            mflag_q   <= mflag_d;
            oflag_q   <= oflag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        payload_d = payload_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        len_d     = len_q;
        wait_d    = wait_q;
        txn_d     = txn_q;
        tflag_d   = tflag_q;
        mflag_d   = mflag_q;
        oflag_d   = oflag_q;
        err_inc   = 1'b0;
        timed_out = (wait_q == WW'(TIMEOUT - 1));

        case (state_q)
            IDLE: begin
                if (tick && enable && mode != MODE_RSVD) begin
                    state_d   = WRITE;
                    mode_d    = mode_e'(mode);
                    payload_d = (mode == MODE_MSG) ? msg_mem[idx_q] : cnt_q;
                    len_d     = (msg_len == '0) ? LW'(1) : msg_len;
                    wait_d    = '0;
                end
            end
            WRITE: begin
                // Ready beats a same-cycle timeout; the payload source only
                // advances once the write has actually been accepted.
                if (mem_ready) begin
                    wait_d = '0;
                    if (mode_q == MODE_MSG)
                        idx_d = (({1'b0, idx_q} + 1'b1) >= len_q) ? '0 : idx_q + 1'b1;
                    else
                        cnt_d = cnt_q + 1'b1;
                    if (mode_q == MODE_RDBK) begin
                        state_d = READ;
                    end else begin
                        state_d = IDLE;
                        txn_d   = txn_q + 16'd1;
                    end
                end else if (timed_out) begin
                    state_d = IDLE;
                    tflag_d = 1'b1;
                    err_inc = 1'b1;
                    txn_d   = txn_q + 16'd1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            READ: begin
                if (mem_ready) begin
                    if (mem_rdata[DATA_W-1:0] != payload_q) begin
                        mflag_d = 1'b1;
                        err_inc = 1'b1;
                    end
                    state_d = IDLE;
                    txn_d   = txn_q + 16'd1;
                end else if (timed_out) begin
                    state_d = IDLE;
                    tflag_d = 1'b1;
                    err_inc = 1'b1;
                    txn_d   = txn_q + 16'd1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tick && state_q != IDLE) oflag_d = 1'b1;
        err_d = (err_inc && err_q != 8'hff) ? err_q + 8'd1 : err_q;
    end

    always_comb begin
        wdata_ext               = '0;
        wdata_ext[DATA_W-1:0]   = payload_q;
        mem_valid     = (state_q != IDLE);
        mem_instr     = 1'b0;
        mem_addr      = mem_valid ? TARGET_ADDR : 32'h0;
        mem_wstrb     = (state_q == WRITE) ? WSTRB : 4'h0;
        mem_wdata     = (state_q == WRITE) ? wdata_ext : 32'h0;
        busy          = mem_valid;
        txn_count     = txn_q;
        err_count     = err_q;
        timeout_flag  = tflag_q;
        mismatch_flag = mflag_q;
        overrun_flag  = oflag_q;
    end

    assign unused_rdata = ^mem_rdata;

endmodule

// File: tb/tb_bus_test_master.sv
// Randomised bench for bus_test_master: a transaction-level reference model
// drives the bus responder and predicts every bus and status output per cycle.
module tb_bus_test_master;

    localparam int P = 10, TMO = 14, DEPTH = 16;
    localparam logic [31:0] ADDR = 32'hffff0040;

    logic        clk = 1'b0, resetn = 1'b0, enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [4:0]  msg_len = 5'd0;
    logic        msg_we = 1'b0;
    logic [3:0]  msg_waddr = 4'd0;
    logic [7:0]  msg_wdata = 8'd0;
    logic        mem_valid, mem_instr, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;
    logic [3:0]  mem_wstrb;
    logic        busy, timeout_flag, mismatch_flag, overrun_flag;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    int checks = 0, failures = 0;

    // stimulus configuration
    bit c_rst = 0, c_en = 0, c_we = 0;
    int c_mode = 0, c_len = 0, c_wa = 0, c_wd = 0;
    int dmin = 1, dmax = 1, bad_pct = 0;

    // reference model
    int          n = 0;
    bit          m_busy = 0, m_rd = 0, m_bad = 0, m_tf = 0, m_mf = 0, m_of = 0;
    int          m_el = 0, m_delay = 0, m_mode = 0, m_len = 1, m_cnt = 0, m_idx = 0;
    logic [7:0]  m_pay = 8'h0, m_err = 8'h0;
    logic [15:0] m_txn = 16'h0;
    logic [7:0]  m_msg [DEPTH];

    always #5 clk = ~clk;

    bus_test_master #(
        .TICK_PERIOD(P), .TARGET_ADDR(ADDR), .DATA_W(8), .MSG_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .mode(mode), .msg_len(msg_len),
        .msg_we(msg_we), .msg_waddr(msg_waddr), .msg_wdata(msg_wdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .busy(busy), .txn_count(txn_count), .err_count(err_count),
        .timeout_flag(timeout_flag), .mismatch_flag(mismatch_flag), .overrun_flag(overrun_flag)
    );

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    task automatic new_phase();
        m_delay = dmin + int'($urandom_range(dmax - dmin));
        m_bad   = ($urandom % 100) < bad_pct;
    endtask

    task automatic finish_txn(input bit e);
        m_busy = 0;
        m_txn  = m_txn + 16'd1;
        if (e && m_err != 8'hff) m_err = m_err + 8'd1;
    endtask

    task automatic step();
        bit tick;
        logic [69:0] exp_bus;
        @(negedge clk);
        exp_bus = {m_busy, m_busy ? ADDR : 32'h0, (m_busy && !m_rd) ? 4'b0001 : 4'b0000,
                   (m_busy && !m_rd) ? {24'h0, m_pay} : 32'h0, 1'b0};
        chk("bus", {mem_valid, mem_addr, mem_wstrb, mem_wdata, mem_instr}, exp_bus);
        chk("stat", {busy, txn_count, err_count, timeout_flag, mismatch_flag, overrun_flag},
            {m_busy, m_txn, m_err, m_tf, m_mf, m_of});

        resetn    = !c_rst;
        enable    = c_en;
        mode      = c_mode[1:0];
        msg_len   = c_len[4:0];
        msg_we    = c_we;
        msg_waddr = c_wa[3:0];
        msg_wdata = c_wd[7:0];
        mem_ready = m_busy && (m_el >= m_delay);
        mem_rdata = $urandom;
        if (m_busy && m_rd) mem_rdata[7:0] = m_pay ^ {7'b0, m_bad};

        if (c_rst) begin
            m_busy = 0; m_rd = 0; m_cnt = 0; m_idx = 0; m_txn = 0; m_err = 0;
            m_tf = 0; m_mf = 0; m_of = 0; n = 0;
        end else begin
            tick = ((n + 1) % P) == 0;
            if (m_busy) begin
                if (tick) m_of = 1;
                if (mem_ready) begin
                    if (!m_rd) begin
                        if (m_mode == 1) m_idx = (m_idx + 1 >= m_len) ? 0 : m_idx + 1;
                        else             m_cnt = (m_cnt + 1) % 256;
                        if (m_mode == 2) begin
                            m_rd = 1; m_el = 0; new_phase();
                        end else finish_txn(0);
                    end else begin
                        if (mem_rdata[7:0] != m_pay) m_mf = 1;
                        finish_txn(mem_rdata[7:0] != m_pay);
                    end
                end else if (m_el + 1 == TMO) begin
                    m_tf = 1;
                    finish_txn(1);
                end else m_el++;
            end else if (tick && c_en && c_mode != 3) begin
                m_busy = 1; m_rd = 0; m_el = 0; m_mode = c_mode;
                m_pay  = (c_mode == 1) ? m_msg[m_idx] : m_cnt[7:0];
                m_len  = (c_len == 0) ? 1 : c_len;
                new_phase();
            end
            n++;
        end
        if (c_we) m_msg[c_wa] = c_wd[7:0];
        @(posedge clk);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic do_reset();
        c_rst = 1; step(); c_rst = 0;
    endtask

    task automatic set_delay(input int lo, input int hi);
        dmin = lo; dmax = hi;
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // counter writes, ready one cycle after valid
        do_reset();
        c_en = 1; c_mode = 0; set_delay(1, 1); bad_pct = 0;
        run(45); #1;
        chk("cnt_txn", 70'(txn_count), 70'd4);
        chk("cnt_err", 70'(err_count), 70'd0);

        // message "Hi!" with index wrap
        do_reset();
        c_we = 1; c_wa = 0; c_wd = 8'h48; step();
        c_wa = 1; c_wd = 8'h69; step();
        c_wa = 2; c_wd = 8'h21; step();
        c_we = 0; c_mode = 1; c_len = 3;
        run(37); #1;
        chk("msg_wrap", {mem_valid, mem_wdata}, {1'b1, 32'h48});
        run(5); #1;
        chk("msg_txn", 70'(txn_count), 70'd4);

        // ready never arrives: timeout, payload not advanced
        do_reset();
        c_mode = 0; set_delay(99, 99);
        run(25); #1;
        chk("tmo_flag", 70'({timeout_flag, overrun_flag}), 70'b11);
        chk("tmo_err", 70'(err_count), 70'd1);
        set_delay(1, 1);
        run(5); #1;
        chk("tmo_pay", {mem_valid, mem_wdata}, {1'b1, 32'h0});
        run(5);

        // readback mismatch every launch
        do_reset();
        c_mode = 2; set_delay(1, 1); bad_pct = 100;
        run(45); #1;
        chk("rb_err", 70'({mismatch_flag, err_count, txn_count}), {45'h0, 1'b1, 8'd4, 16'd4});
        bad_pct = 0;

        // long ready hold-off overlaps a tick
        do_reset();
        c_mode = 0; set_delay(12, 12);
        run(29); #1;
        chk("ovr", 70'({overrun_flag, timeout_flag, txn_count}), {52'h0, 1'b1, 1'b0, 16'd1});

        // reset mid-write clears everything, counter restarts at 0
        set_delay(99, 99);
        run(3);
        do_reset(); #1;
        chk("rst_mid", 70'({mem_valid, txn_count, err_count, timeout_flag, overrun_flag}), 70'd0);
        set_delay(1, 1);
        run(10); #1;
        chk("rst_pay", {mem_valid, mem_wdata}, {1'b1, 32'h0});
        run(5);

        // ready on the final allowed cycle beats the timeout
        do_reset();
        set_delay(TMO - 1, TMO - 1);
        run(29); #1;
        chk("tie", 70'({timeout_flag, err_count, txn_count}), {45'h0, 1'b0, 8'd0, 16'd1});

        // randomised traffic
        do_reset();
        c_we = 1;
        for (int i = 0; i < DEPTH; i++) begin
            c_wa = i; c_wd = int'($urandom_range(255)); step();
        end
        c_we = 0; set_delay(0, 16); bad_pct = 30;
        for (int i = 0; i < 4000; i++) begin
            c_en = ($urandom % 8) != 0;
            if ($urandom % 16 == 0) c_mode = int'($urandom_range(3));
            if ($urandom % 32 == 0) c_len  = int'($urandom_range(16));
            c_we = ($urandom % 4) == 0;
            c_wa = int'($urandom_range(DEPTH - 1));
            c_wd = int'($urandom_range(255));
            c_rst = ($urandom % 700) == 0;
            step();
        end
        c_rst = 0; c_we = 0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
